// File: rtl/r_type_issue_wb.sv
// r_type_issue_wb: issue/writeback sequencer for RV32I R-type instructions.
// It owns the integer register file. It reads rs1/rs2 and presents the latched
// instruction and operands to an external combinational execution unit. It then
// captures that unit's result and writes it back to rd.
// Every transaction follows IDLE -> READ -> EXEC -> WB, so one instruction
// completes every four cycles. An illegal encoding returns to IDLE straight
// from READ.
module r_type_issue_wb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [31:0]     alu_instr,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic [XLEN-1:0] alu_out,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam logic [6:0] OpcodeOp  = 7'b0110011;
    localparam logic [6:0] Funct7Std = 7'b0000000;
    localparam logic [6:0] Funct7Alt = 7'b0100000;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWb
    } state_e;

    state_e          state_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] alu_in1_q;
    logic [XLEN-1:0] alu_in2_q;
    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            illegal_q;

    // x0 is never written, so regs_q[0] stays at its reset value of zero.
    logic [XLEN-1:0] regs_q [NREGS];

    // Field extraction from the latched instruction.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];

    logic            is_legal;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // R-type legality: funct7 = 0100000 is only defined for sub and sra.
    always_comb begin
        is_legal = 1'b0;
        if (opcode == OpcodeOp) begin
            if (funct7 == Funct7Std) begin
                is_legal = 1'b1;
            end else if (funct7 == Funct7Alt) begin
                is_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
            end
        end
    end

    // Operand reads; x0 always reads as zero.
    always_comb begin
        rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1];
        rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2];
    end

    // Sequencer FSM with registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            alu_in1_q  <= '0;
            alu_in2_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    if (is_legal) begin
                        alu_in1_q <= rs1_val;
                        alu_in2_q <= rs2_val;
                        state_q   <= StExec;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StExec: begin
                    // wb_data_q doubles as the result register; it holds after WB.
                    wb_data_q  <= alu_out;
                    wb_rd_q    <= rd;
                    wb_valid_q <= 1'b1;
                    state_q    <= StWb;
                end
                StWb: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Register file write at the end of WB; a result aimed at x0 is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == StWb && wb_rd_q != 5'd0) begin
            regs_q[wb_rd_q] <= wb_data_q;
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign alu_instr   = instr_q;
    assign alu_in1     = alu_in1_q;
    assign alu_in2     = alu_in2_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign illegal     = illegal_q;
    assign dbg_data    = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_r_type_issue_wb.sv
// Bench for r_type_issue_wb. An execution-unit model sits on the ALU port and
// can be overridden to inject arbitrary results. Expected values come from a
// register-array model updated by the architectural rules.
module tb_r_type_issue_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_instr;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int passed = 0;

    logic [31:0] model [32];
    logic        force_en  = 1'b0;
    logic [31:0] force_val = '0;

    always #5 clk = ~clk;

    r_type_issue_wb #(.XLEN(32), .NREGS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .alu_instr  (alu_instr),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_out    (alu_out),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] b);
        case (ins[14:12])
            3'd0:    return ins[30] ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // External execution unit, optionally overridden to seed arbitrary values.
    always_comb alu_out = force_en ? force_val : alu_ref(alu_instr, alu_in1, alu_in2);

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic bit legal_ref(input logic [31:0] ins);
        if (ins[6:0] != 7'b0110011) return 1'b0;
        if (ins[31:25] == 7'h00) return 1'b1;
        if (ins[31:25] == 7'h20) return (ins[14:12] == 3'd0) || (ins[14:12] == 3'd5);
        return 1'b0;
    endfunction

    // Issues one instruction and follows it cycle by cycle against the model.
    task automatic do_instr(input logic [31:0] ins);
        int          n;
        bit          leg;
        logic [4:0]  rd;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] er;
        leg = legal_ref(ins);
        rd  = ins[11:7];
        ea  = model[ins[19:15]];
        eb  = model[ins[24:20]];
        er  = force_en ? force_val : alu_ref(ins, ea, eb);
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) $display("FAIL ready_wait: got %b want 1", instr_ready);
        else passed++;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        @(negedge clk);
        checks++;
        if ({instr_ready, wb_valid, illegal} !== 3'b000)
            $display("FAIL read_cycle rdy/wb/ill: got %b want 000", {instr_ready, wb_valid, illegal});
        else passed++;
        @(negedge clk);
        if (!leg) begin
            checks++;
            if ({illegal, wb_valid, instr_ready} !== 3'b101)
                $display("FAIL illegal_pulse ill/wb/rdy: got %b want 101",
                         {illegal, wb_valid, instr_ready});
            else passed++;
            @(negedge clk);
            checks++;
            if ({illegal, wb_valid} !== 2'b00)
                $display("FAIL illegal_end ill/wb: got %b want 00", {illegal, wb_valid});
            else passed++;
        end else begin
            checks++;
            if ({alu_instr, alu_in1, alu_in2} !== {ins, ea, eb})
                $display("FAIL exec_operands: got %h %h %h want %h %h %h",
                         alu_instr, alu_in1, alu_in2, ins, ea, eb);
            else passed++;
            checks++;
            if ({illegal, wb_valid, instr_ready} !== 3'b000)
                $display("FAIL exec_flags ill/wb/rdy: got %b want 000",
                         {illegal, wb_valid, instr_ready});
            else passed++;
            @(negedge clk);
            checks++;
            if ({wb_valid, wb_rd, wb_data} !== {1'b1, rd, er})
                $display("FAIL writeback v/rd/data: got %b %0d %h want 1 %0d %h",
                         wb_valid, wb_rd, wb_data, rd, er);
            else passed++;
            if (rd != 5'd0) model[rd] = er;
            @(negedge clk);
            dbg_addr = rd;
            #1;
            checks++;
            if ({wb_valid, instr_ready, wb_rd, wb_data, dbg_data} !==
                {1'b0, 1'b1, rd, er, model[rd]})
                $display("FAIL after_wb v/rdy/rd/data/dbg: got %b %b %0d %h %h want 0 1 %0d %h %h",
                         wb_valid, instr_ready, wb_rd, wb_data, dbg_data, rd, er, model[rd]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        checks++;
        if ({instr_ready, wb_valid, illegal, wb_rd, wb_data, alu_instr, alu_in1, alu_in2} !==
            {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0})
            $display("FAIL reset_outputs: got %b %b %b %0d %h %h %h %h want 1 0 0 0 all-zero",
                     instr_ready, wb_valid, illegal, wb_rd, wb_data, alu_instr, alu_in1, alu_in2);
        else passed++;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #0.5;
            checks++;
            if (dbg_data !== 32'd0) $display("FAIL reset_reg x%0d: got %h want 0", i, dbg_data);
            else passed++;
        end
    endtask

    task automatic test_seed_and_add();
        force_en  = 1'b1;
        force_val = 32'd7;
        do_instr(rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd1));
        force_val = 32'd5;
        do_instr(rtype(7'h20, 5'd0, 5'd0, 3'd0, 5'd2));
        force_en = 1'b0;
        do_instr(32'h002081B3);
        checks++;
        if (model[3] !== 32'd12) $display("FAIL add_x3 model: got %h want 0000000c", model[3]);
        else passed++;
    endtask

    task automatic test_sub_sra();
        do_instr(rtype(7'h20, 5'd1, 5'd2, 3'd0, 5'd4));
        do_instr(rtype(7'h20, 5'd1, 5'd4, 3'd5, 5'd6));
        dbg_addr = 5'd6;
        #1;
        checks++;
        if (dbg_data !== 32'hFFFF_FFFF) $display("FAIL sra_x6: got %h want ffffffff", dbg_data);
        else passed++;
    endtask

    task automatic test_x0_dest();
        do_instr(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd0));
    endtask

    task automatic test_illegal();
        do_instr(32'h0000_0013);
        do_instr(rtype(7'h20, 5'd2, 5'd1, 3'd1, 5'd5));
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #0.5;
            checks++;
            if (dbg_data !== model[i])
                $display("FAIL illegal_regs x%0d: got %h want %h", i, dbg_data, model[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [2:0]  f3;
        logic [6:0]  f7;
        for (int k = 0; k < 40; k++) begin
            f3 = 3'($urandom_range(0, 7));
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            ins = rtype(f7, 5'($urandom), 5'($urandom), f3, 5'($urandom));
            if ($urandom_range(0, 7) == 0) ins = $urandom;
            force_en  = ($urandom_range(0, 2) == 0);
            force_val = $urandom;
            do_instr(ins);
        end
        force_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        int wb_seen;
        @(negedge clk);
        instr       = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd7);
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        wb_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wb_valid !== 1'b0) wb_seen++;
        end
        checks++;
        if (wb_seen != 0) $display("FAIL reset_abort_wb: got %0d pulses want 0", wb_seen);
        else passed++;
        dbg_addr = 5'd7;
        #1;
        checks++;
        if ({instr_ready, dbg_data} !== {1'b1, 32'd0})
            $display("FAIL reset_abort_x7 rdy/x7: got %b %h want 1 0", instr_ready, dbg_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int accepts[$];
        int wb_cnt;
        force_en  = 1'b1;
        force_val = $urandom;
        wb_cnt    = 0;
        @(negedge clk);
        instr       = rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd8);
        instr_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            if (instr_ready === 1'b1) accepts.push_back(c);
            if (wb_valid === 1'b1) wb_cnt++;
        end
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (accepts.size() != 6 || wb_cnt != 6)
            $display("FAIL b2b_counts accepts/wb: got %0d %0d want 6 6", accepts.size(), wb_cnt);
        else passed++;
        for (int i = 1; i < accepts.size(); i++) begin
            checks++;
            if (accepts[i] - accepts[i-1] != 4)
                $display("FAIL b2b_spacing #%0d: got %0d want 4", i, accepts[i] - accepts[i-1]);
            else passed++;
        end
        model[8] = force_val;
        dbg_addr = 5'd8;
        #1;
        checks++;
        if (dbg_data !== model[8]) $display("FAIL b2b_x8: got %h want %h", dbg_data, model[8]);
        else passed++;
        force_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_seed_and_add();
        test_sub_sra();
        test_x0_dest();
        test_illegal();
        test_random();
        test_reset_mid();
        test_seed_and_add();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/r_type_issue_wb.md
Name: r_type_issue_wb

Overview:
- Issue/writeback sequencer on the initiator side of the R-type execution interface.
- Accepts one RV32I R-type instruction per transaction over a valid/ready handshake.
- Owns the 32x32 integer register file and reads rs1/rs2 from it.
- Drives instruction and operands to the external combinational R-type execution unit, captures its result, and writes rd back.
- Sits between fetch/decode and the R-type ALU in the multi-cycle core.

Parameters:
- XLEN, 32, data width of registers, operands and result.
- NREGS, 32, number of architectural registers; x0 is hardwired zero.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  upstream offers an instruction.
- instr  input  32  RV32I instruction word.
- instr_ready  output  1  block can accept an instruction (high only in IDLE).
- alu_instr  output  32  latched instruction presented to the execution unit.
- alu_in1  output  XLEN  rs1 operand to the execution unit.
- alu_in2  output  XLEN  rs2 operand to the execution unit.
- alu_out  input  XLEN  combinational result from the execution unit.
- wb_valid  output  1  one-cycle pulse: writeback performed this cycle.
- wb_rd  output  5  destination register of the writeback.
- wb_data  output  XLEN  value written.
- illegal  output  1  one-cycle pulse: accepted instruction was not a legal R-type.
- dbg_addr  input  5  debug register read address.
- dbg_data  output  XLEN  combinational register file read; 0 when dbg_addr == 0.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; all registers x0..x31 = 0; instr_ready = 1; wb_valid = 0, illegal = 0; wb_rd = 0, wb_data = 0; alu_instr = 0, alu_in1 = 0, alu_in2 = 0.
- Reset asserted mid-transaction aborts it: no register write, no pulse, and the next cycle is IDLE.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. An illegal instruction takes READ -> IDLE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch instr into the instruction register and go to READ.
  - instr is ignored while instr_ready = 0; upstream holds it.
- READ:
  - Decode the latched instruction.
  - Legal R-type: opcode[6:0] = 7'b0110011, and funct7 = 7'b0000000 for any funct3, or funct7 = 7'b0100000 with funct3 = 000 (sub) or 101 (sra).
  - Legal: load alu_in1 = x[rs1] and alu_in2 = x[rs2], with x0 reading 0. Go to EXEC.
  - Illegal: pulse illegal for the next cycle, leave registers unchanged, go to IDLE.
- EXEC:
  - alu_instr, alu_in1 and alu_in2 are stable registered outputs.
  - Sample alu_out into the result register at the end of the cycle. Go to WB.
- WB:
  - wb_valid = 1, wb_rd = rd, wb_data = captured result.
  - Write x[rd] at the end of the cycle unless rd == 0. wb_valid still pulses for rd == 0 and wb_data shows the discarded value.
  - Go to IDLE.
- Timing:
  - Handshake at rising edge N gives wb_valid high during cycle N+3.
  - The written value is visible on dbg_data and to the next instruction from cycle N+4.
  - Next accept is possible at edge N+4, so throughput is 1 instruction per 4 cycles.
- No forwarding is needed: transactions are serialized and the register write completes before the next READ.
- wb_rd and wb_data hold their last values outside WB. wb_valid and illegal are low except during their single pulse cycle.
- Operands are raw XLEN bit vectors. Signedness is interpreted by the execution unit only.
- rs1 == rs2 == rd (e.g. add x5,x5,x5) reads the old value and writes the new value.

Test Plan:
- Reset, then read dbg_data for all 32 addresses -> every value is 0; instr_ready = 1.
- Seed x1 = 7 and x2 = 5 via prior add/sub sequences from x0, then issue add x3,x1,x2 (0x002081B3) -> wb_valid in cycle N+3 with wb_rd = 3, wb_data = 12; dbg_data(x3) = 12 at N+4.
- sub x4,x2,x1 with the ALU model attached -> wb_data = 0xFFFFFFFE; issue sra x6,x4,x1 -> alu_in2 = 7, wb_data = 0xFFFFFFFF.
- add x0,x1,x2 -> wb_valid pulses with wb_rd = 0; dbg_data(0) stays 0.
- Issue 0x00000013 (addi, I-type) and then funct7 = 0100000 with funct3 = 001 -> illegal pulses 2 cycles after accept, no wb_valid, register file unchanged, instr_ready back to 1.
- Assert reset during EXEC of add x7,x1,x2 -> x7 stays 0, no wb_valid; also hold instr_valid high back-to-back -> accepts only at 4-cycle spacing.
